// File: rtl/vm80a_intc.sv
// vm80a_intc: eight-input vectored interrupt controller for the vm80a bus.
// Latches rising edges on irq into a pending register, presents a masked,
// prioritised request to the CPU and, during the interrupt-acknowledge cycle,
// drives the RST opcode matching the serviced line. The mask register and
// the pending register (write-one-to-clear) are memory mapped.
module vm80a_intc #(
  parameter logic [15:0] BASE_ADDR = 16'hFFF0
) (
  input  logic        pin_clk,
  input  logic        pin_reset,
  input  logic [7:0]  irq,
  input  logic [15:0] a,
  input  logic [7:0]  dout,
  input  logic        wr_n,
  input  logic        sync,
  output logic        int_req,
  output logic        inta,
  output logic        sel,
  output logic [7:0]  dint
);

  localparam logic [15:0] PEND_ADDR = BASE_ADDR + 16'd1;

  logic [7:0] irq_q;
  logic [7:0] pending;
  logic [7:0] mask;
  logic [2:0] vec_id;
  logic       sync_q;

  logic [7:0] rise;
  logic [7:0] active;
  logic       hit_mask;
  logic       hit_pend;
  logic       capture;
  logic       ack_set;
  logic [2:0] lowest_id;
  logic [7:0] ack_clr;
  logic [7:0] sw_clr;
  logic [7:0] pending_next;
  logic [7:0] vector;

  assign rise     = irq & ~irq_q;
  assign active   = pending & ~mask;
  assign hit_mask = (a == BASE_ADDR);
  assign hit_pend = (a == PEND_ADDR);
  assign capture  = sync & ~sync_q;
  assign ack_set  = capture & dout[0];
  assign vector   = 8'hC7 | {2'b00, vec_id, 3'b000};

  // Priority encoder: lowest set bit of active wins; 7 when nothing is active,
  // which doubles as the spurious-acknowledge vector (RST 7).
  always_comb begin
    lowest_id = 3'd7;
    for (int i = 7; i >= 0; i--) begin
      if (active[i]) lowest_id = i[2:0];
    end
  end

  // Pending update: clears first, then new edges, so an edge beats a clear.
  always_comb begin
    ack_clr = 8'h00;
    sw_clr  = 8'h00;
    if (ack_set && (active != 8'h00)) ack_clr = 8'h01 << lowest_id;
    if (!wr_n && hit_pend) sw_clr = dout;
    pending_next = (pending & ~(ack_clr | sw_clr)) | rise;
  end

  // Read mux: vector during acknowledge, otherwise the addressed register.
  always_comb begin
    dint = 8'h00;
    if (inta)          dint = vector;
    else if (hit_mask) dint = mask;
    else if (hit_pend) dint = pending;
    sel = inta | hit_mask | hit_pend;
  end

  // Register state; irq_q keeps tracking during reset so held lines stay quiet.
  always_ff @(posedge pin_clk) begin
    irq_q <= irq;
    if (pin_reset) begin
      mask    <= 8'hFF;
      pending <= 8'h00;
      inta    <= 1'b0;
      int_req <= 1'b0;
      vec_id  <= 3'd0;
      sync_q  <= 1'b0;
    end else begin
      sync_q  <= sync;
      pending <= pending_next;
      if (!wr_n && hit_mask) mask <= dout;
      if (capture) inta <= dout[0];
      if (ack_set) vec_id <= lowest_id;
      int_req <= (|active) & ~inta & ~ack_set;
    end
  end

endmodule
